// File: rtl/sram_mem_stage_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
// Holds the controller state encoding, default base address and bus widths.
package sram_mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int BASE_ADDR_DEF = 1024;
  localparam int DQ_W          = 16;
  localparam int WORD_W        = 32;

endpackage

// File: rtl/sram_mem_stage_wait.sv
// Wait counter: clear, count enable, terminal flag at WAIT_CYCLES-1.
// Ports: clk, rst, clr, en in; tc out.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_stage.sv
// Memory-stage SRAM controller: one 32-bit access = two 16-bit SRAM accesses.
// Ports: pipeline rdEn/wrEn/address/writeData in, readData/ready out; SRAM bus.
module sram_mem_stage
  import sram_mem_stage_pkg::*;
#(
  parameter int BASE_ADDR   = BASE_ADDR_DEF,
  parameter int WAIT_CYCLES = 3,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdEn,
  input  logic              wrEn,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] writeData,
  output logic [WORD_W-1:0] readData,
  output logic              ready,
  inout  wire  [DQ_W-1:0]   SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  state_t              state_q;
  state_t              state_d;
  logic                op_wr_q;
  logic [ADDR_W-2:0]   word_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   rdata_q;
  logic                ld;
  logic                cnt_clr;
  logic                cnt_en;
  logic                tc;
  logic                acc;
  logic                hi;
  logic                drive;
  logic [DQ_W-1:0]     dq_out;

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .tc (tc)
  );

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = ~(rdEn | wrEn);
        if (rdEn | wrEn) begin
          ld      = 1'b1;
          cnt_clr = 1'b1;
          state_d = ACC_LO;
        end
      end
      ACC_LO: begin
        if (tc) begin
          cnt_clr = 1'b1;
          state_d = ACC_HI;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ACC_HI: begin
        if (tc) begin
          cnt_clr = 1'b1;
          state_d = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        // request still high here belongs to the finishing access
        ready   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign acc = (state_q == ACC_LO) || (state_q == ACC_HI);
  assign hi  = (state_q == ACC_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (ld) begin
        op_wr_q <= wrEn;
        // wraps modulo the SRAM word space; address[1:0] drops out
        word_q  <= (ADDR_W-1)'((address - 32'(BASE_ADDR)) >> 2);
        wdata_q <= writeData;
      end
      if (acc && !op_wr_q && tc) begin
        if (hi) rdata_q[31:16] <= SRAM_DQ;
        else    rdata_q[15:0]  <= SRAM_DQ;
      end
    end
  end

  assign drive  = acc & op_wr_q;
  assign dq_out = hi ? wdata_q[31:16] : wdata_q[15:0];

  assign SRAM_DQ   = drive ? dq_out : {DQ_W{1'bz}};
  assign SRAM_ADDR = {word_q, hi};
  assign SRAM_WE_N = ~drive;
  assign SRAM_OE_N = drive;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign readData  = rdata_q;

endmodule

// File: doc/sram_mem_stage.md
Name: sram_mem_stage

Overview:
- Memory-stage SRAM controller. Consumes the memRead/memWrite/address/store-data fields that the decode-stage control unit generates and the EX/MEM register carries.
- Converts each 32-bit word access into two sequential 16-bit accesses on the external SRAM.
- Drops ready while busy; hazard/freeze logic uses this to stall all earlier pipeline registers.
- Returns load data to the MEM/WB register.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM halfword 0.
- WAIT_CYCLES, 3: cycles each halfword access is held on the SRAM bus (≥1).
- ADDR_W, 18: SRAM halfword address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdEn  in  1  load request (memRead from the pipeline).
- wrEn  in  1  store request (memWrite from the pipeline).
- address  in  32  byte address (ALU result).
- writeData  in  32  store data (Rm value).
- readData  out  32  load result; held until the next completed load.
- ready  out  1  1 = no access in flight or access completing this cycle; 0 = pipeline must freeze.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  ADDR_W  halfword address.
- SRAM_WE_N  out  1  write enable, active low.
- SRAM_OE_N  out  1  output enable, active low.
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  tied 0.

Behaviour:
- Address map: word = (address − BASE_ADDR) >> 2, modulo 2^(ADDR_W−1). Low half at SRAM_ADDR = {word, 0}; high half at {word, 1}. Out-of-range addresses wrap silently; address[1:0] is ignored.
- States: IDLE, ACC_LO, ACC_HI, DONE.
- IDLE:
  - ready = ~(rdEn | wrEn), combinational.
  - On a request: register the op (write if wrEn, else read; wrEn wins if both), the word address and writeData; clear the wait counter; go to ACC_LO.
- ACC_LO:
  - Drive the low address; counter increments each cycle.
  - Write: SRAM_DQ = wdata[15:0], SRAM_WE_N = 0.
  - Read: SRAM_DQ high-Z, SRAM_OE_N = 0; on the last cycle (counter == WAIT_CYCLES−1) capture SRAM_DQ into readData[15:0].
  - Go to ACC_HI after WAIT_CYCLES cycles; counter clears.
- ACC_HI: same as ACC_LO using the high address and wdata[31:16] / readData[31:16]; then go to DONE.
- DONE: ready = 1 for exactly one cycle; unconditionally return to IDLE. A request still asserted in DONE belongs to the completing instruction and is not restarted.
- Latency: request sampled in IDLE at cycle 0; ready = 0 in cycles 0..2W; ready = 1 in cycle 2W+1, where W = WAIT_CYCLES (default: ready rises in cycle 7).
- Back-to-back requests: a new request may start on the cycle after DONE.
- Inputs (rdEn, wrEn, address, writeData) changing during ACC_* are ignored; the latched values are used.
- A write never modifies readData. A read updates readData only at its capture cycles, so a partially completed read leaves readData mixed until DONE.
- Outside ACC_* with a write op: SRAM_WE_N = 1, SRAM_OE_N = 0, SRAM_DQ high-Z.
- Reset (any cycle, including mid-access): state = IDLE, counter = 0, readData = 0, latched op/addr/data = 0, SRAM_WE_N = 1, DQ high-Z. An interrupted access is abandoned, not replayed.
- SRAM_WE_N and DQ drive come from registered state only (no input-to-strobe combinational path).

Decomposition:
- Shared package: state encoding (2 bits), BASE_ADDR default, SRAM bus widths.
- One natural sub-module: sram_wait_counter (clear, enable, terminal-count flag at WAIT_CYCLES−1). The rest stays in one module.

Test Plan:
- Store then load: wrEn, address = 1024, writeData = 0xDEADBEEF. Response: SRAM model halfword 0 = 0xBEEF, halfword 1 = 0xDEAD; ready low for 7 cycles, high in cycle 7. Then rdEn, address = 1024 → readData = 0xDEADBEEF in cycle 7.
- Address mapping: wrEn, address = 1032, data = 0x12345678. Response: SRAM_ADDR 4 gets 0x5678, SRAM_ADDR 5 gets 0x1234. Also address = 1035 hits the same word (low bits ignored).
- Idle behaviour: no request for 10 cycles. Response: ready = 1, SRAM_WE_N = 1, DQ high-Z, readData unchanged.
- Input change mid-access: rdEn at word 0, then switch the request to wrEn, address 2000 in cycle 3. Response: the read completes from word 0, no SRAM write occurs, and a new access starts only from IDLE.
- Reset mid-write: rst pulsed in cycle 4 of a write. Response: immediately SRAM_WE_N = 1, ready = 1 (IDLE, no request), readData = 0.
- Both enables set: rdEn = wrEn = 1, address = 1024, writeData = 0xA5A5A5A5. Response: write performed, readData unchanged.
